ps2_host_rx: RTL and testbench
==============================

// Module: ps2_host_rx
// PURPOSE
//  Host-side PS/2 receiver: deserialises device-to-host frames (start, 8 data LSB-first, odd parity, stop)
//  from the keyboard's ps2_clk/ps2_data lines. Sits beside the host transmitter on the same wires and
//  feeds received scancodes/ACKs to the keyboard decoder. Receive-only: never drives the bus.
// PARAMETERS
//  FILTER_LEN     8     ps2_clk glitch-filter depth in clk cycles (level accepted after FILTER_LEN equal samples)
//  TIMEOUT_CYCLES 2500  max clk cycles between ps2_clk falling edges inside a frame before abort
//  TW             12    width of timeout counter; TIMEOUT_CYCLES < 2**TW
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high
//  ps2_clk   in   1  PS/2 clock line (asynchronous)
//  ps2_data  in   1  PS/2 data line (asynchronous)
//  inhibit   in   1  high while host transmitter owns the bus; aborts/blocks reception
//  rx_data   out  8  last correctly received byte
//  rx_valid  out  1  one-cycle strobe: rx_data updated this cycle
//  rx_err    out  1  one-cycle strobe: parity, stop-bit or timeout error
//  busy      out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, rx_err=0, busy=0, state=IDLE, filter regs all 1, filtered clk=1,
//   data sync regs 2'b11, bit count 0, timeout count 0. Reset mid-frame discards the frame, no strobe.
//  Clock filter: FILTER_LEN-bit shift of ps2_clk; filtered level (registered) becomes 1 on all-ones,
//   0 on all-zeros, else holds. fall = filtered_d & ~filtered (one-cycle pulse).
//  Data: 2-flop synchroniser; data_s sampled only in cycles where fall=1.
//  FSM (bit count 0..8):
//   IDLE   : fall & data_s=0 -> DATA, cnt=0. fall & data_s=1 -> stay IDLE, no error.
//   DATA   : on fall shift data_s into shreg[7] (shift right); cnt++; after 8th bit -> PARITY.
//   PARITY : on fall latch parity bit -> STOP.
//   STOP   : on fall: if stop=1 and ^{shreg,parity}=1 -> rx_data<=shreg, rx_valid=1 next cycle;
//            else rx_err=1 next cycle, rx_data unchanged. -> IDLE either way.
//  Latency: strobes are registered; assert in the cycle after the stop-bit fall pulse; exactly 1 cycle wide.
//  rx_valid and rx_err never assert in the same cycle.
//  Timeout: counter cleared on every fall and in IDLE; increments otherwise (saturating at TIMEOUT_CYCLES-1);
//   reaching TIMEOUT_CYCLES-1 outside IDLE -> rx_err strobe, -> IDLE. A fall in that same cycle is ignored.
//  Inhibit: while inhibit=1 state forced IDLE, counters cleared, no strobes (abort is silent, not an error);
//   filter/sync keep running so reception resumes cleanly one fall after inhibit drops.
//  Back-to-back frames: new start bit accepted on the first fall after returning to IDLE.
//  Filter pulses shorter than FILTER_LEN cycles on ps2_clk produce no fall and no state change.
// TESTING
//  1 Frame 0x1C (bits 0,00111000,par0,stop1), 40 clk per half-period -> one rx_valid, rx_data=0x1C, rx_err=0.
//  2 Frame 0xF0 with parity 0 (correct is 1) -> one rx_err, no rx_valid, rx_data keeps 0x1C.
//  3 Frame 0xAA with stop bit 0 -> rx_err; then valid 0x55 frame -> rx_valid, rx_data=0x55.
//  4 3-cycle low glitch on ps2_clk while IDLE and mid-DATA -> no state change, frame 0x12 still received intact.
//  5 Stop clocking after 5 data bits -> rx_err exactly TIMEOUT_CYCLES-1 cycles after last fall, busy=0;
//    following 0xE0 frame received correctly.
//  6 inhibit=1 after 4 bits -> busy=0 next cycle, no strobes; reset asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: filters ps2_clk, synchronises ps2_data, deserialises start/8 data/odd parity/stop frames.
// Strobes (rx_valid / rx_err) are registered, one cycle wide, asserted the cycle after the stop-bit fall pulse.
module ps2_host_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2500,
    parameter int TW             = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       inhibit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(TIMEOUT_CYCLES - 2);

    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  filt_clk_d;
    logic [1:0]            data_sync;
    logic                  data_s;
    logic                  fall;

    state_t                state;
    logic [3:0]            cnt;
    logic [7:0]            shreg;
    logic                  par;
    logic [TW-1:0]         tcnt;
    logic                  timeout;

    // Filter and synchroniser keep running through inhibit so reception restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_sr    <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            data_sync  <= 2'b11;
        end else begin
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], ps2_clk};
            filt_clk_d <= filt_clk;
            data_sync  <= {data_sync[0], ps2_data};
            if (&filt_sr)
                filt_clk <= 1'b1;
            else if (~|filt_sr)
                filt_clk <= 1'b0;
        end
    end

    assign fall    = filt_clk_d & ~filt_clk;
    assign data_s  = data_sync[1];
    // Fires on the edge where the counter reaches its last value; a coincident fall is ignored.
    assign timeout = (state != IDLE) && (tcnt == T_PRE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            shreg    <= 8'd0;
            par      <= 1'b0;
            tcnt     <= '0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (inhibit) begin
                state <= IDLE;
                cnt   <= 4'd0;
                tcnt  <= '0;
            end else begin
                if (state == IDLE || fall)
                    tcnt <= '0;
                else if (tcnt != T_LAST)
                    tcnt <= tcnt + TW'(1);

                if (timeout) begin
                    rx_err <= 1'b1;
                    state  <= IDLE;
                    cnt    <= 4'd0;
                end else if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state <= DATA;
                                cnt   <= 4'd0;
                            end
                        end
                        DATA: begin
                            shreg <= {data_s, shreg[7:1]};
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par   <= data_s;
                            state <= STOP;
                        end
                        STOP: begin
                            if (data_s && (^{shreg, par})) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_err <= 1'b1;
                            end
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Testbench for ps2_host_rx: drives PS/2 device frames and checks strobes/data against a frame-level model.
module tb_ps2_host_rx;
    localparam int FL   = 8;
    localparam int TO   = 2500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       inhibit = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int vld_cyc = 0;
    int err_cyc = 0;
    int both_cyc = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;

    ps2_host_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .TW(12)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .inhibit(inhibit),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid) vld_cyc++;
        if (rx_err) err_cyc++;
        if (rx_valid && rx_err) both_cyc++;
    end

    // Frame word as it appears on the wire, bit 0 first: {stop, parity, data, start}.
    function automatic logic [10:0] mk(input logic [7:0] b, input logic par_ok, input logic stop);
        logic p;
        p = par_ok ? ~(^b) : (^b);
        return {stop, p, b, 1'b0};
    endfunction

    // Reference rule: start 0, stop 1, odd number of ones across data and parity.
    function automatic logic frame_good(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int k = 1; k <= 9; k++) ones += int'(f[k]);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (ones % 2 == 1);
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (i == glitch_at && c == 10) ps2_clk = 1'b0;
                if (i == glitch_at && c == 13) ps2_clk = 1'b1;
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    // Sends a complete frame and compares strobe counts and rx_data with the model.
    task automatic test_frame(input string name, input logic [10:0] f, input int glitch_at);
        int v0, e0, ev, ee;
        v0 = vld_cyc; e0 = err_cyc;
        send_bits(f, 11, glitch_at);
        repeat (10) @(negedge clk);
        ev = frame_good(f) ? 1 : 0;
        ee = 1 - ev;
        if (frame_good(f)) exp_data = f[8:1];
        checks++; if (vld_cyc - v0 !== ev) begin errors++; $display("FAIL %s valid_cycles got %0d want %0d", name, vld_cyc - v0, ev); end
        checks++; if (err_cyc - e0 !== ee) begin errors++; $display("FAIL %s err_cycles got %0d want %0d", name, err_cyc - e0, ee); end
        checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL %s rx_data got %h want %h", name, rx_data, exp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = vld_cyc; e0 = err_cyc;
        @(negedge clk); ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle busy got %b want 0", busy); end
        checks++; if ((vld_cyc - v0) + (err_cyc - e0) !== 0) begin errors++; $display("FAIL glitch_idle strobes got %0d want 0", (vld_cyc - v0) + (err_cyc - e0)); end
        test_frame("glitch_frame_12", mk(8'h12, 1'b1, 1'b1), 3);
    endtask

    task automatic test_timeout();
        logic [10:0] f;
        int v0, e0, n;
        f = mk(8'h3C, 1'b1, 1'b1);
        v0 = vld_cyc; e0 = err_cyc;
        send_bits(f, 5, -1);
        ps2_data = f[5];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == HALF) ps2_clk = 1'b1;
            if (rx_err) break;
        end
        ps2_data = 1'b1;
        // Fall is consumed FL+2 edges after ps2_clk drops; the strobe follows TO-1 cycles later.
        checks++; if (n !== FL + 2 + (TO - 1)) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, FL + 2 + (TO - 1)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (err_cyc - e0 !== 1) begin errors++; $display("FAIL timeout_err_cycles got %0d want 1", err_cyc - e0); end
        checks++; if (vld_cyc - v0 !== 0) begin errors++; $display("FAIL timeout_valid got %0d want 0", vld_cyc - v0); end
        test_frame("after_timeout_E0", mk(8'hE0, 1'b1, 1'b1), -1);
    endtask

    task automatic test_inhibit_and_reset();
        int v0, e0;
        v0 = vld_cyc; e0 = err_cyc;
        send_bits(mk(8'h9B, 1'b1, 1'b1), 5, -1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inhibit_pre_busy got %b want 1", busy); end
        inhibit = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inhibit_busy got %b want 0", busy); end
        repeat (100) @(negedge clk);
        inhibit = 1'b0;
        repeat (TO + 20) @(negedge clk);
        checks++; if ((vld_cyc - v0) + (err_cyc - e0) !== 0) begin errors++; $display("FAIL inhibit_strobes got %0d want 0", (vld_cyc - v0) + (err_cyc - e0)); end
        test_frame("after_inhibit_5A", mk(8'h5A, 1'b1, 1'b1), -1);

        v0 = vld_cyc; e0 = err_cyc;
        send_bits(mk(8'h77, 1'b1, 1'b1), 4, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_data = 8'h00;
        checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL midreset_rx_data got %h want 00", rx_data); end
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL midreset_outputs got busy=%b vld=%b err=%b want 0 0 0", busy, rx_valid, rx_err); end
        reset = 1'b0;
        repeat (TO + 20) @(negedge clk);
        checks++; if ((vld_cyc - v0) + (err_cyc - e0) !== 0) begin errors++; $display("FAIL midreset_strobes got %0d want 0", (vld_cyc - v0) + (err_cyc - e0)); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int mode;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            mode = $urandom_range(0, 3);
            test_frame($sformatf("rand%0d", i), mk(b, mode != 2, mode != 3), -1);
        end
        checks++; if (both_cyc !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", both_cyc); end
    endtask

    initial begin
        test_reset();
        test_frame("frame_1C", mk(8'h1C, 1'b1, 1'b1), -1);
        test_frame("bad_parity_F0", mk(8'hF0, 1'b0, 1'b1), -1);
        test_frame("bad_stop_AA", mk(8'hAA, 1'b1, 1'b0), -1);
        test_frame("frame_55", mk(8'h55, 1'b1, 1'b1), -1);
        test_glitch();
        test_timeout();
        test_inhibit_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
